serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
// PURPOSE
//   Bit-serial companion to the 4-bit registered adder: computes A - B LSB-first, one bit per clock.
//   Operands arrive on a valid/ready input handshake; the result leaves on a valid/ready output handshake.
//   Used as the inverse path (difference/borrow) beside the adder in the arithmetic test datapath.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (>= 2); also the number of SHIFT cycles per operation
// PORTS
//   clk        in   1      system clock, rising-edge
//   rst        in   1      reset, asynchronous, active-high
//   in_valid   in   1      operands valid
//   in_ready   out  1      block can accept operands (high only in IDLE)
//   data_in1   in   WIDTH  minuend A, unsigned
//   data_in2   in   WIDTH  subtrahend B, unsigned
//   out_valid  out  1      data_out/borrow valid (high only in DONE)
//   out_ready  in   1      consumer accepts result
//   data_out   out  WIDTH  difference A - B
//   borrow     out  1      1 when A < B (unsigned underflow)
// BEHAVIOUR
//   - Reset (async, any state, any cycle): state=IDLE, data_out=0, borrow=0, out_valid=0, bit counter=0, internal borrow=0; in_ready=1 after reset.
//   - FSM: IDLE -> SHIFT on in_valid&&in_ready; SHIFT -> DONE on the edge that processes bit WIDTH-1;
//     DONE -> IDLE on out_valid&&out_ready. No other transitions.
//   - Accept (edge N): latch A, B into shift registers; clear counter and internal borrow.
//   - SHIFT, per edge: d = a0^b0^br; br' = (~a0&b0) | (~(a0^b0)&br); shift A, B right; shift d into result MSB.
//   - Latency: accept on edge N -> out_valid high after edge N+WIDTH. Throughput: one op per WIDTH+2 cycles min.
//   - data_out/borrow change only on the final SHIFT edge; stable for the whole of DONE.
//   - Result is exact modulo 2^WIDTH; borrow = final internal borrow.
//   - in_valid while not IDLE: ignored, operands not latched, no side effect.
//   - out_ready while not DONE: ignored. Backpressure: DONE holds indefinitely with outputs unchanged.
//   - Operand inputs are sampled only at the accept edge; later changes have no effect.
//   - Reset mid-SHIFT or mid-DONE: operation discarded, no out_valid pulse.
// CONFIGURATION
//   SUB_SAT_EN defined: when borrow=1, data_out is forced to 0 at the DONE transition (saturating subtract); borrow still reported 1.
//   SUB_SAT_EN undefined: data_out is the wrapped modulo-2^WIDTH difference. Timing/handshake identical both ways.
// STRUCTURE
//   Shared package/include adder_pkg: FSM state encodings (ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2), default WIDTH.
//   One sub-module: full_sub_bit (a, b, bin -> d, bout), combinational, instantiated once in the serial loop.
//   Top holds FSM, counter ($clog2(WIDTH) bits), operand/result shift registers, borrow flop.
// TESTING
//   1. 14-2 (A=4'b1110, B=4'b0010), out_ready=1 -> out_valid 4 cycles after accept, data_out=4'b1100, borrow=0.
//   2. 2-4 (A=4'b0010, B=4'b0100) -> data_out=4'b1110, borrow=1; with SUB_SAT_EN data_out=4'b0000, borrow=1.
//   3. Back-to-back 1-1 then 15-0 -> 4'b0000/0 then 4'b1111/0; in_ready low from accept until DONE handshake.
//   4. out_ready=0 for 10 cycles in DONE -> out_valid, data_out, borrow held constant; then 1 cycle out_ready -> IDLE, in_ready=1.
//   5. in_valid pulsed with A=7,B=3 during SHIFT of 9-5 -> ignored; result 4'b0100, borrow=0.
//   6. rst asserted 2 cycles into SHIFT -> all outputs 0 immediately (async), in_ready=1; next op 8-3 -> 4'b0101.

Source files
------------

// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adder_pkg
// Description : Shared definitions for the 4-bit arithmetic test datapath.
//               Holds the bit-serial FSM state encoding and the default
//               operand width used by the adder and serial_subtractor.
// Config      : none (SUB_SAT_EN is consumed by serial_subtractor only)
// Revision    : 1.0 - initial release
// ============================================================================
package adder_pkg;

   // Default operand/result width of the arithmetic datapath
   localparam int DEFAULT_WIDTH = 4;

   // Bit-serial engine states; encodings are shared with the adder so that
   // both blocks look alike in waveforms and debug registers.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage : adder_pkg
`default_nettype wire

// File: rtl/serial_subtractor_full_sub_bit.sv
`default_nettype none
// ============================================================================
// Module      : full_sub_bit
// Description : One-bit full subtractor, purely combinational.
//               d    = a - b - bin   (difference bit)
//               bout = borrow out of this bit position
// Ports       : a    in  1  minuend bit
//               b    in  1  subtrahend bit
//               bin  in  1  borrow in from the less significant bit
//               d    out 1  difference bit
//               bout out 1  borrow out to the more significant bit
// Revision    : 1.0 - initial release
// ============================================================================
module full_sub_bit (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_axb;

   assign w_axb = a ^ b;
   assign d     = w_axb ^ bin;
   // Borrow when b exceeds a outright, or when a == b and a borrow is pending
   assign bout  = (~a & b) | (~w_axb & bin);

endmodule : full_sub_bit
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Bit-serial unsigned subtractor computing A - B LSB-first,
//               one bit per clock. Operands enter on a valid/ready handshake,
//               the difference and borrow leave on a valid/ready handshake.
//               An operation takes WIDTH SHIFT cycles; out_valid rises WIDTH
//               edges after the accept edge.
// Config      : SUB_SAT_EN - when defined, an underflowing result (borrow=1)
//               is clamped to zero on entry to DONE; borrow still reads 1.
//               When undefined, data_out is the wrapped modulo-2^WIDTH value.
// Parameters  : WIDTH     operand/result width, >= 2
// Ports       : clk       in   1      rising-edge clock
//               rst       in   1      asynchronous active-high reset
//               in_valid  in   1      operands valid
//               in_ready  out  1      ready for operands (IDLE only)
//               data_in1  in   WIDTH  minuend A
//               data_in2  in   WIDTH  subtrahend B
//               out_valid out  1      result valid (DONE only)
//               out_ready in   1      consumer takes the result
//               data_out  out  WIDTH  difference A - B
//               borrow    out  1      set when A < B
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
   import adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in1,
   input  logic [WIDTH-1:0] data_in2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] data_out,
   output logic             borrow
);

   localparam int               CNT_W    = $clog2(WIDTH);
   localparam int               RES_W    = WIDTH - 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // ------------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------------
   state_e             state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic [WIDTH-1:0]   a_q,      a_d;
   logic [WIDTH-1:0]   b_q,      b_d;
   // Partial result holds only WIDTH-1 bits: the last difference bit is
   // taken straight from the subtractor cell on the final SHIFT edge.
   logic [RES_W-1:0]   res_q,    res_d;
   logic               br_q,     br_d;
   logic [WIDTH-1:0]   dout_q,   dout_d;
   logic               borrow_q, borrow_d;

   logic               w_diff;
   logic               w_bout;
   logic [WIDTH-1:0]   w_full;
   logic               w_accept;

   // ------------------------------------------------------------------------
   // Single serial subtractor cell working on the operand LSBs
   // ------------------------------------------------------------------------
   full_sub_bit u_full_sub_bit (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (br_q),
      .d    (w_diff),
      .bout (w_bout)
   );

   // Result as it stands once the current bit is shifted in
   assign w_full   = {w_diff, res_q};
   assign w_accept = in_valid && (state_q == ST_IDLE);

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         res_q    <= '0;
         br_q     <= 1'b0;
         dout_q   <= '0;
         borrow_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         res_q    <= res_d;
         br_q     <= br_d;
         dout_q   <= dout_d;
         borrow_q <= borrow_d;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and datapath update logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      br_d     = br_q;
      dout_d   = dout_q;
      borrow_d = borrow_q;

      case (state_q)
         ST_IDLE: begin
            if (w_accept) begin
               a_d     = data_in1;
               b_d     = data_in2;
               res_d   = '0;
               cnt_d   = '0;
               br_d    = 1'b0;
               state_d = ST_SHIFT;
            end
         end

         ST_SHIFT: begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            res_d = RES_W'(w_full >> 1);
            br_d  = w_bout;
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               // Outputs only move here, so they stay stable through DONE
               // and keep their value while idle afterwards.
               dout_d   = w_full;
               borrow_d = w_bout;
`ifdef SUB_SAT_EN
               if (w_bout) begin
                  dout_d = '0;
               end
`endif
               state_d  = ST_DONE;
            end
         end

         ST_DONE: begin
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign data_out  = dout_q;
   assign borrow    = borrow_q;

endmodule : serial_subtractor
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (WIDTH=4).
//               Expected results are computed by a wide-subtraction model
//               and queued when operands are accepted, then popped and
//               compared when the DUT presents out_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

   localparam int W = 4;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] data_in1;
   logic [W-1:0] data_in2;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] data_out;
   logic         borrow;

   int           total;
   int           bad;
   logic [W:0]   sb_q[$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in1  (data_in1),
      .data_in2  (data_in2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .borrow    (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: subtract in W+1 bits, the top bit is the borrow
   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0] full;
      full = {1'b0, a} - {1'b0, b};
`ifdef SUB_SAT_EN
      if (full[W]) full[W-1:0] = '0;
`endif
      return full;
   endfunction

   // Present operands for one edge (caller ensures in_ready), then scramble
   // the operand bus so late changes would show up in the result.
   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
      in_valid = 1'b1;
      data_in1 = a;
      data_in2 = b;
      if (push) sb_q.push_back(model(a, b));
      @(posedge clk); #1;
      in_valid = 1'b0;
      data_in1 = W'($urandom);
      data_in2 = W'($urandom);
   endtask

   // Cycles from now until out_valid, bounded at 40
   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; data_in1 = '0; data_in2 = '0;
      #12;
      total++;
      if ({in_ready, out_valid, borrow, data_out} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
         bad++;
         $display("FAIL reset_state got rdy=%b vld=%b br=%b d=%h want rdy=1 vld=0 br=0 d=0",
                  in_ready, out_valid, borrow, data_out);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int cyc;
      logic [W:0] exp;
      out_ready = 1'b1;
      send_op(4'b1110, 4'b0010, 1'b1);
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL basic_busy in_ready=%b want 0", in_ready);
      end
      wait_valid(cyc);
      total++;
      if (cyc != W) begin
         bad++; $display("FAIL basic_latency got=%0d want=%0d", cyc, W);
      end
      exp = sb_q.pop_front();
      total++;
      if ({borrow, data_out} !== exp) begin
         bad++; $display("FAIL basic_result got br=%b d=%b want br=%b d=%b", borrow, data_out, exp[W], exp[W-1:0]);
      end
      @(posedge clk); #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL basic_release vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      logic [W:0] exp;
      out_ready = 1'b1;
      send_op(4'd1, 4'd1, 1'b1);
      for (int i = 0; i < W; i++) begin
         total++;
         if (in_ready !== 1'b0) begin
            bad++; $display("FAIL b2b_ready_low cycle=%0d in_ready=%b want 0", i, in_ready);
         end
         if (out_valid === 1'b1) break;
         @(posedge clk); #1;
      end
      wait_valid(cyc);
      exp = sb_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || {borrow, data_out} !== exp) begin
         bad++; $display("FAIL b2b_first got vld=%b br=%b d=%b want vld=1 br=%b d=%b",
                         out_valid, borrow, data_out, exp[W], exp[W-1:0]);
      end
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1) begin
         bad++; $display("FAIL b2b_ready_back in_ready=%b want 1", in_ready);
      end
      send_op(4'd15, 4'd0, 1'b1);
      wait_valid(cyc);
      exp = sb_q.pop_front();
      total++;
      if (cyc != W || {borrow, data_out} !== exp) begin
         bad++; $display("FAIL b2b_second got cyc=%0d br=%b d=%b want cyc=%0d br=%b d=%b",
                         cyc, borrow, data_out, W, exp[W], exp[W-1:0]);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      int cyc;
      logic [W:0] exp;
      out_ready = 1'b0;
      send_op(4'b0010, 4'b0100, 1'b1);
      wait_valid(cyc);
      exp = sb_q.pop_front();
      total++;
      if (out_valid !== 1'b1 || {borrow, data_out} !== exp) begin
         bad++; $display("FAIL under_result got vld=%b br=%b d=%b want vld=1 br=%b d=%b",
                         out_valid, borrow, data_out, exp[W], exp[W-1:0]);
      end
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         total++;
         if ({out_valid, in_ready, borrow, data_out} !== {1'b1, 1'b0, exp}) begin
            bad++; $display("FAIL hold cycle=%0d got vld=%b rdy=%b br=%b d=%b want vld=1 rdy=0 br=%b d=%b",
                            i, out_valid, in_ready, borrow, data_out, exp[W], exp[W-1:0]);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL hold_release vld=%b rdy=%b want vld=0 rdy=1", out_valid, in_ready);
      end
      out_ready = 1'b1;
   endtask

   task automatic test_random();
      int cyc;
      logic [W:0] exp;
      logic [W-1:0] a, b;
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         send_op(a, b, 1'b1);
         wait_valid(cyc);
         exp = sb_q.pop_front();
         total++;
         if (cyc != W || {borrow, data_out} !== exp) begin
            bad++; $display("FAIL rand a=%h b=%h got cyc=%0d br=%b d=%b want cyc=%0d br=%b d=%b",
                            a, b, cyc, borrow, data_out, W, exp[W], exp[W-1:0]);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_ignore_in_valid();
      int cyc;
      logic [W:0] exp;
      out_ready = 1'b1;
      send_op(4'd9, 4'd5, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b1; data_in1 = 4'd7; data_in2 = 4'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      wait_valid(cyc);
      exp = sb_q.pop_front();
      total++;
      if (cyc + 2 != W || {borrow, data_out} !== exp) begin
         bad++; $display("FAIL ignore_result got lat=%0d br=%b d=%b want lat=%0d br=%b d=%b",
                         cyc + 2, borrow, data_out, W, exp[W], exp[W-1:0]);
      end
      @(posedge clk); #1;
      // A stray accept would start a second operation here
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         bad++; $display("FAIL ignore_idle rdy=%b vld=%b want rdy=1 vld=0", in_ready, out_valid);
      end
   endtask

   task automatic test_reset_mid_shift();
      int cyc;
      int seen;
      logic [W:0] exp;
      out_ready = 1'b1;
      send_op(4'd12, 4'd1, 1'b0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      #2 rst = 1'b1;
      #1;
      total++;
      if ({in_ready, out_valid, borrow, data_out} !== {1'b1, 1'b0, 1'b0, 4'h0}) begin
         bad++; $display("FAIL async_reset got rdy=%b vld=%b br=%b d=%h want rdy=1 vld=0 br=0 d=0",
                         in_ready, out_valid, borrow, data_out);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid === 1'b1) seen++;
         @(posedge clk); #1;
      end
      total++;
      if (seen != 0) begin
         bad++; $display("FAIL reset_no_pulse got=%0d want=0", seen);
      end
      send_op(4'd8, 4'd3, 1'b1);
      wait_valid(cyc);
      exp = sb_q.pop_front();
      total++;
      if (cyc != W || {borrow, data_out} !== exp) begin
         bad++; $display("FAIL after_reset got cyc=%0d br=%b d=%b want cyc=%0d br=%b d=%b",
                         cyc, borrow, data_out, W, exp[W], exp[W-1:0]);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_ignore_in_valid();
      test_reset_mid_shift();
      total++;
      if (sb_q.size() != 0) begin
         bad++; $display("FAIL scoreboard_left got=%0d want=0", sb_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_serial_subtractor
`default_nettype wire
